sorted_window_median: RTL

- Running-median engine on the consumer side of the median filter's W-deep sample delay line.
- Each accepted cycle takes the newest sample and the sample leaving the window (the delay-line tap at depth W).
- Keeps a sorted register array of the current window by deleting the outgoing sample and inserting the incoming one.
- Outputs the registered centre element (the median) with a valid strobe.

---
 rtl/sorted_window_median.sv | 114 +++++++++++
 1 files changed

// File: rtl/sorted_window_median.sv
// Running median over a W-sample window kept as a sorted register array.
// Optional MEDIAN_MINMAX_EN adds registered window minimum/maximum outputs.
module sorted_window_median #(
    parameter int DATA_LENGTH = 16,
    parameter int W           = 101
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_LENGTH-1:0]   new_sample,
    input  logic [DATA_LENGTH-1:0]   old_sample,
    output logic [DATA_LENGTH-1:0]   median_out,
    output logic                     median_valid,
    output logic [$clog2(W+1)-1:0]   fill_count,
    output logic                     warm,
`ifdef MEDIAN_MINMAX_EN
    output logic [DATA_LENGTH-1:0]   min_out,
    output logic [DATA_LENGTH-1:0]   max_out,
`endif
    output logic                     mismatch_err
);

    localparam int M  = (W - 1) / 2;
    localparam int FW = $clog2(W + 1);

    logic [DATA_LENGTH-1:0] s_r     [W];
    logic [DATA_LENGTH-1:0] nxt_s   [W];
    logic [DATA_LENGTH-1:0] t_s     [W];
    logic [DATA_LENGTH-1:0] tsh_s   [W];
    logic [W-1:0]           eq_s;
    logic [W-1:0]           lt_s;
    logic [W-1:0]           prev_ge_s;
    logic                   found_s;
    logic                   acc_s;

    // Delete-then-insert network: t_s is the array with the first copy of
    // old_sample removed (last slot unused), then new_sample is slotted in
    // after every t_s element smaller than it.
    always_comb begin
        acc_s = 1'b0;
        for (int i = 0; i < W; i++) begin
            eq_s[i] = (s_r[i] == old_sample);
        end
        found_s = |eq_s;
        for (int j = 0; j < W - 1; j++) begin
            acc_s  = acc_s | eq_s[j];
            t_s[j] = acc_s ? s_r[j+1] : s_r[j];
            lt_s[j] = (t_s[j] < new_sample);
        end
        t_s[W-1]     = new_sample;
        lt_s[W-1]    = 1'b0;
        tsh_s[0]     = new_sample;
        prev_ge_s[0] = 1'b0;
        for (int i = 1; i < W; i++) begin
            tsh_s[i]     = t_s[i-1];
            prev_ge_s[i] = ~lt_s[i-1];
        end
        for (int i = 0; i < W; i++) begin
            if (!found_s) begin
                nxt_s[i] = s_r[i];
            end else if (lt_s[i]) begin
                nxt_s[i] = t_s[i];
            end else if (prev_ge_s[i]) begin
                nxt_s[i] = tsh_s[i];
            end else begin
                nxt_s[i] = new_sample;
            end
        end
    end

    // Window array, registered outputs, fill counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < W; i++) begin
                s_r[i] <= '0;
            end
            median_out   <= '0;
            median_valid <= 1'b0;
            fill_count   <= '0;
            mismatch_err <= 1'b0;
`ifdef MEDIAN_MINMAX_EN
            min_out      <= '0;
            max_out      <= '0;
`endif
        end else begin
            median_valid <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < W; i++) begin
                    s_r[i] <= nxt_s[i];
                end
                median_out <= nxt_s[M];
`ifdef MEDIAN_MINMAX_EN
                min_out    <= nxt_s[0];
                max_out    <= nxt_s[W-1];
`endif
                if (fill_count != FW'(W)) begin
                    fill_count <= fill_count + FW'(1);
                end else begin
                    fill_count <= fill_count;
                end
                if (!found_s) begin
                    mismatch_err <= 1'b1;
                end else begin
                    mismatch_err <= mismatch_err;
                end
            end else begin
                median_out <= median_out;
            end
        end
    end

    assign warm = (fill_count == FW'(W));

endmodule
